regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single write port (we/wa/wd) of register_file among 3 writeback requesters
//  (0=ALU, 1=MEM, 2=IO) using a valid/ready handshake and round-robin or fixed-priority arbitration.
//  Registers the winning write onto the regfile port and forwards the in-flight write onto both
//  read ports (rd1/rd2) so decode never reads a stale value. Sits between writeback and register_file.
// PARAMETERS
//  DATA_W     32  data width of the regfile word
//  ADDR_W     3   regfile address width (8 registers)
//  PRIO_MODE  0   0 = round-robin, 1 = fixed priority (lowest index wins)
// PORTS
//  clk        in   1          system clock, posedge
//  rst        in   1          asynchronous reset, active-high
//  req_valid  in   3          per-requester write request
//  req_ready  out  3          per-requester grant; transfer when valid & ready
//  req_addr   in   3*ADDR_W   requester i address at [ADDR_W*i +: ADDR_W]
//  req_data   in   3*DATA_W   requester i data at [DATA_W*i +: DATA_W]
//  rf_we      out  1          to register_file we
//  rf_wa      out  ADDR_W     to register_file wa
//  rf_wd      out  DATA_W     to register_file wd
//  ra1, ra2   in   ADDR_W     read addresses from decode, passed through as rf_ra1/rf_ra2
//  rf_ra1/2   out  ADDR_W     to register_file ra1/ra2 (combinational copy of ra1/ra2)
//  rf_rd1/2   in   DATA_W     from register_file rd1/rd2
//  rd1, rd2   out  DATA_W     bypassed read data to decode
//  wr_cnt     out  16         count of writes issued to the regfile, wraps at 16'hFFFF -> 0
// BEHAVIOUR
//  Reset (async, immediate): rf_we=0, rf_wa=0, rf_wd=0, wr_cnt=0, rr_ptr=2 (requester 0 wins first).
//   In-flight write is dropped. req_ready is combinational; with rst high, req_ready=0.
//  Arbitration (combinational, each cycle, at most one grant):
//   PRIO_MODE=0: search starts at (rr_ptr+1) mod 3; first valid requester wins.
//   PRIO_MODE=1: lowest-index valid requester wins; rr_ptr not used.
//   req_ready[i]=1 only for the winner; all zero when no request is valid.
//  Requester rules: addr/data held stable while valid=1 and ready=0; valid is not withdrawn before
//   acceptance. Addresses are taken as ADDR_W bits; wider encodings are the requester's fault.
//  Issue (posedge after grant): rf_we<=|grant; if granted: rf_wa<=addr, rf_wd<=data, rr_ptr<=winner,
//   wr_cnt<=wr_cnt+1. No grant: rf_we<=0; rf_wa/rf_wd/rr_ptr/wr_cnt hold.
//  Latency: accepted at edge N -> rf_we=1 during cycle N..N+1 -> register written at edge N+1.
//   Back-to-back grants give one write per cycle, full throughput.
//  Bypass (combinational): rd1 = (rf_we && rf_wa==ra1) ? rf_wd : rf_rd1; rd2 likewise with ra2.
//   Only the in-flight write is forwarded; older writes are already in register_file.
//  Same address granted in consecutive cycles: writes commit in grant order; last grant wins;
//   bypass shows whichever write is currently in flight.
//  All registers are 0 after reset; r0 is not special.
// TESTING  (bench instantiates regfile_wb_arbiter + register_file, 100-unit clk)
//  1 Reset: pulse rst mid-cycle while rf_we=1 -> rf_we/rf_wa/rf_wd/wr_cnt=0 before the next edge;
//    next grant goes to requester 0.
//  2 Single write: valid[1], addr=3, data=32'haaaaaaaa -> ready[1]=1 same cycle; next cycle
//    rf_we=1 wa=3 wd=aaaaaaaa, ra1=3 gives rd1=aaaaaaaa via bypass; after the edge, rf_rd1=aaaaaaaa
//    and wr_cnt=1.
//  3 Round-robin: all three valid for 6 cycles -> grants 0,1,2,0,1,2; wr_cnt=6; drop valid[1] ->
//    order 0,2,0,2.
//  4 PRIO_MODE=1: all valid -> requester 0 granted every cycle; 1 and 2 get ready=0 until
//    valid[0]=0, then 1 before 2.
//  5 Same address: req0 r5=32'h12345678 then req1 r5=32'h87654321 on consecutive grants ->
//    rd2 (ra2=5) reads 12345678 then 87654321; final r5=87654321.
//  6 Idle: no valid for 4 cycles -> rf_we=0, ready=0, wr_cnt and rr_ptr unchanged; reads come
//    straight from rf_rd1/rf_rd2.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file write port.
// Three requesters (0=ALU, 1=MEM, 2=IO) share one registered write port.
// Arbitration is round-robin or fixed-priority. The in-flight write is
// forwarded onto both read ports.
module regfile_wb_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 3,
    parameter int PRIO_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req_valid,
    output logic [2:0]            req_ready,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [3*DATA_W-1:0]   req_data,
    output logic                  rf_we,
    output logic [ADDR_W-1:0]     rf_wa,
    output logic [DATA_W-1:0]     rf_wd,
    input  logic [ADDR_W-1:0]     ra1,
    input  logic [ADDR_W-1:0]     ra2,
    output logic [ADDR_W-1:0]     rf_ra1,
    output logic [ADDR_W-1:0]     rf_ra2,
    input  logic [DATA_W-1:0]     rf_rd1,
    input  logic [DATA_W-1:0]     rf_rd2,
    output logic [DATA_W-1:0]     rd1,
    output logic [DATA_W-1:0]     rd2,
    output logic [15:0]           wr_cnt
);

    logic [1:0]        rr_ptr;
    logic [1:0]        winner;
    logic [1:0]        idx;
    logic              found;
    logic [2:0]        grant;
    logic [ADDR_W-1:0] gaddr;
    logic [DATA_W-1:0] gdata;

    // Pick at most one winner among the valid requesters.
    always_comb begin
        grant  = '0;
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        if (PRIO_MODE != 0) begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (!found && req_valid[i]) begin
                    found  = 1'b1;
                    winner = 2'(i);
                end
            end
        end else begin
            // Search order starts one past the last winner, wrapping modulo 3.
            for (int unsigned k = 0; k < 3; k++) begin
                idx = 2'((32'(rr_ptr) + 32'd1 + k) % 32'd3);
                if (!found && req_valid[idx]) begin
                    found  = 1'b1;
                    winner = idx;
                end
            end
        end
        if (found) begin
            grant[winner] = 1'b1;
        end
    end

    // Handshake grant, suppressed while reset is asserted.
    always_comb begin
        req_ready = rst ? '0 : grant;
    end

    // Select the winning requester's address and data.
    always_comb begin
        gaddr = req_addr[ADDR_W*winner +: ADDR_W];
        gdata = req_data[DATA_W*winner +: DATA_W];
    end

    // Register the granted write onto the regfile port and advance the pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we  <= 1'b0;
            rf_wa  <= '0;
            rf_wd  <= '0;
            wr_cnt <= '0;
            rr_ptr <= 2'd2;
        end else begin
            rf_we <= |grant;
            if (|grant) begin
                rf_wa  <= gaddr;
                rf_wd  <= gdata;
                rr_ptr <= winner;
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end

    // Read addresses pass straight through; in-flight write bypasses stale read data.
    always_comb begin
        rf_ra1 = ra1;
        rf_ra2 = ra2;
        rd1    = (rf_we && (rf_wa == ra1)) ? rf_wd : rf_rd1;
        rd2    = (rf_we && (rf_wa == ra2)) ? rf_wd : rf_rd2;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a round-robin and a fixed-priority instance,
// each backed by a small behavioural register file, checked against a
// per-instance reference model plus constant vector tables.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;
    always #50 clk = ~clk;

    logic [2:0]      valid  [2];
    logic [3*AW-1:0] addr   [2];
    logic [3*DW-1:0] data   [2];
    logic [AW-1:0]   ra1, ra2;
    logic [2:0]      ready  [2];
    logic            we     [2];
    logic [AW-1:0]   wa     [2];
    logic [DW-1:0]   wd     [2];
    logic [AW-1:0]   rfra1  [2];
    logic [AW-1:0]   rfra2  [2];
    logic [DW-1:0]   rfrd1  [2];
    logic [DW-1:0]   rfrd2  [2];
    logic [DW-1:0]   rd1    [2];
    logic [DW-1:0]   rd2    [2];
    logic [15:0]     cnt    [2];
    logic [DW-1:0]   rf_mem [2][8];

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PRIO_MODE(0)) u_rr (
        .clk(clk), .rst(rst), .req_valid(valid[0]), .req_ready(ready[0]),
        .req_addr(addr[0]), .req_data(data[0]), .rf_we(we[0]), .rf_wa(wa[0]),
        .rf_wd(wd[0]), .ra1(ra1), .ra2(ra2), .rf_ra1(rfra1[0]), .rf_ra2(rfra2[0]),
        .rf_rd1(rfrd1[0]), .rf_rd2(rfrd2[0]), .rd1(rd1[0]), .rd2(rd2[0]), .wr_cnt(cnt[0])
    );

    regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PRIO_MODE(1)) u_pr (
        .clk(clk), .rst(rst), .req_valid(valid[1]), .req_ready(ready[1]),
        .req_addr(addr[1]), .req_data(data[1]), .rf_we(we[1]), .rf_wa(wa[1]),
        .rf_wd(wd[1]), .ra1(ra1), .ra2(ra2), .rf_ra1(rfra1[1]), .rf_ra2(rfra2[1]),
        .rf_rd1(rfrd1[1]), .rf_rd2(rfrd2[1]), .rd1(rd1[1]), .rd2(rd2[1]), .wr_cnt(cnt[1])
    );

    // Stand-in register files: cleared by reset, written on rf_we, async read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++)
                for (int r = 0; r < 8; r++)
                    rf_mem[d][r] <= '0;
        end else begin
            for (int d = 0; d < 2; d++)
                if (we[d]) rf_mem[d][wa[d]] <= wd[d];
        end
    end

    assign rfrd1[0] = rf_mem[0][rfra1[0]];
    assign rfrd2[0] = rf_mem[0][rfra2[0]];
    assign rfrd1[1] = rf_mem[1][rfra1[1]];
    assign rfrd2[1] = rf_mem[1][rfra2[1]];

    // Reference model state per instance (0 = round-robin, 1 = fixed priority).
    bit          m_we   [2];
    logic [2:0]  m_wa   [2];
    logic [31:0] m_wd   [2];
    int          m_cnt  [2];
    int          m_rr   [2];
    logic [31:0] m_regs [2][8];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0] v;
        logic [2:0] exp_rr;
        logic [2:0] exp_pr;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
        end
    endtask

    // Winner from the arbitration rules: lowest index, or first valid after the last winner.
    function automatic int pick(input int d, input logic [2:0] v);
        if (d == 1) begin
            for (int i = 0; i < 3; i++) if (v[i]) return i;
        end else begin
            for (int k = 0; k < 3; k++) begin
                int j;
                j = (m_rr[d] + 1 + k) % 3;
                if (v[j]) return j;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_we[d] = 1'b0; m_wa[d] = '0; m_wd[d] = '0; m_cnt[d] = 0; m_rr[d] = 2;
            for (int r = 0; r < 8; r++) m_regs[d][r] = '0;
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] a, input logic [31:0] x);
        for (int d = 0; d < 2; d++) begin
            valid[d][i] = v;
            addr[d][AW*i +: AW] = a;
            data[d][DW*i +: DW] = x;
        end
    endtask

    task automatic set_valid(input logic [2:0] v);
        for (int d = 0; d < 2; d++) valid[d] = v;
    endtask

    // One clock cycle: compare all outputs to the model, then advance the model past the edge.
    task automatic cycle(output int w0, output int w1);
        int          w  [2];
        logic [2:0]  a  [2];
        logic [31:0] dd [2];
        logic [31:0] e1, e2;
        #20;
        for (int d = 0; d < 2; d++) begin
            w[d] = pick(d, valid[d]);
            a[d] = '0;
            dd[d] = '0;
            chk("req_ready", d, 32'(ready[d]), (w[d] < 0) ? 32'd0 : (32'd1 << w[d]));
            chk("rf_we", d, 32'(we[d]), 32'(m_we[d]));
            chk("rf_wa", d, 32'(wa[d]), 32'(m_wa[d]));
            chk("rf_wd", d, wd[d], m_wd[d]);
            chk("wr_cnt", d, 32'(cnt[d]), 32'(m_cnt[d]));
            chk("rf_ra1", d, 32'(rfra1[d]), 32'(ra1));
            chk("rf_ra2", d, 32'(rfra2[d]), 32'(ra2));
            e1 = (m_we[d] && m_wa[d] == ra1) ? m_wd[d] : m_regs[d][ra1];
            e2 = (m_we[d] && m_wa[d] == ra2) ? m_wd[d] : m_regs[d][ra2];
            chk("rd1", d, rd1[d], e1);
            chk("rd2", d, rd2[d], e2);
            chk("rf_rd1", d, rfrd1[d], m_regs[d][ra1]);
            if (w[d] >= 0) begin
                a[d]  = addr[d][AW*w[d] +: AW];
                dd[d] = data[d][DW*w[d] +: DW];
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (m_we[d]) m_regs[d][m_wa[d]] = m_wd[d];
            m_we[d] = (w[d] >= 0);
            if (w[d] >= 0) begin
                m_wa[d]  = a[d];
                m_wd[d]  = dd[d];
                m_rr[d]  = w[d];
                m_cnt[d] = (m_cnt[d] + 1) % 65536;
            end
        end
        w0 = w[0];
        w1 = w[1];
    endtask

    initial begin
        int w0, w1;
        int prevw [2];

        tbl[0]  = '{3'b111, 3'b001, 3'b001};
        tbl[1]  = '{3'b111, 3'b010, 3'b001};
        tbl[2]  = '{3'b111, 3'b100, 3'b001};
        tbl[3]  = '{3'b111, 3'b001, 3'b001};
        tbl[4]  = '{3'b111, 3'b010, 3'b001};
        tbl[5]  = '{3'b111, 3'b100, 3'b001};
        tbl[6]  = '{3'b101, 3'b001, 3'b001};
        tbl[7]  = '{3'b101, 3'b100, 3'b001};
        tbl[8]  = '{3'b101, 3'b001, 3'b001};
        tbl[9]  = '{3'b101, 3'b100, 3'b001};
        tbl[10] = '{3'b110, 3'b010, 3'b010};
        tbl[11] = '{3'b110, 3'b100, 3'b010};
        tbl[12] = '{3'b110, 3'b010, 3'b010};
        tbl[13] = '{3'b100, 3'b100, 3'b100};
        tbl[14] = '{3'b000, 3'b000, 3'b000};

        // Reset: requests held high must not see ready while rst is asserted.
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin valid[d] = 3'b111; addr[d] = '0; data[d] = '0; end
        ra1 = '0; ra2 = '0;
        model_reset();
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) chk("ready_in_reset", d, 32'(ready[d]), 32'd0);
        set_valid(3'b000);
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(w0, w1);

        // Single write from requester 1 with bypass and commit.
        set_req(1, 1'b1, 3'd3, 32'haaaaaaaa);
        ra1 = 3'd3;
        #5;
        for (int d = 0; d < 2; d++) chk("single_ready", d, 32'(ready[d]), 32'b010);
        cycle(w0, w1);
        set_valid(3'b000);
        #5;
        for (int d = 0; d < 2; d++) begin
            chk("single_bypass_rd1", d, rd1[d], 32'haaaaaaaa);
            chk("single_we", d, 32'(we[d]), 32'd1);
        end
        cycle(w0, w1);
        #5;
        for (int d = 0; d < 2; d++) begin
            chk("single_rf_rd1", d, rfrd1[d], 32'haaaaaaaa);
            chk("single_cnt", d, 32'(cnt[d]), 32'd1);
        end

        // Reset pulsed mid-cycle while a write is in flight.
        set_req(2, 1'b1, 3'd6, 32'h5a5a5a5a);
        cycle(w0, w1);
        set_valid(3'b000);
        #29;
        for (int d = 0; d < 2; d++) chk("pre_reset_we", d, 32'(we[d]), 32'd1);
        rst = 1'b1;
        set_valid(3'b111);
        #5;
        for (int d = 0; d < 2; d++) begin
            chk("mid_reset_we", d, 32'(we[d]), 32'd0);
            chk("mid_reset_wa", d, 32'(wa[d]), 32'd0);
            chk("mid_reset_wd", d, wd[d], 32'd0);
            chk("mid_reset_cnt", d, 32'(cnt[d]), 32'd0);
            chk("mid_reset_ready", d, 32'(ready[d]), 32'd0);
        end
        #5;
        set_valid(3'b000);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // Arbitration vector table; fixed requester addresses/data.
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 3'(i + 1), 32'hc0de0000 + 32'(i));
        for (int i = 0; i < 15; i++) begin
            set_valid(tbl[i].v);
            #5;
            chk("tbl_ready_rr", i, 32'(ready[0]), 32'(tbl[i].exp_rr));
            chk("tbl_ready_pr", i, 32'(ready[1]), 32'(tbl[i].exp_pr));
            cycle(w0, w1);
            if (i == 5) begin
                chk("rr_cnt6", 0, 32'(cnt[0]), 32'd6);
                chk("pr_cnt6", 1, 32'(cnt[1]), 32'd6);
            end
        end

        // Idle: four cycles with no requests, then requester 0 wins next.
        set_valid(3'b000);
        ra1 = 3'd1; ra2 = 3'd2;
        for (int i = 0; i < 4; i++) begin
            cycle(w0, w1);
            for (int d = 0; d < 2; d++) chk("idle_rd1_direct", d, rd1[d], rfrd1[d]);
        end
        set_valid(3'b111);
        #5;
        chk("post_idle_ready", 0, 32'(ready[0]), 32'b001);
        cycle(w0, w1);
        set_valid(3'b000);

        // Same address granted on consecutive cycles: later write wins.
        set_req(0, 1'b1, 3'd5, 32'h12345678);
        ra2 = 3'd5;
        cycle(w0, w1);
        set_req(0, 1'b0, 3'd5, 32'h12345678);
        set_req(1, 1'b1, 3'd5, 32'h87654321);
        #5;
        for (int d = 0; d < 2; d++) chk("same_addr_first", d, rd2[d], 32'h12345678);
        cycle(w0, w1);
        set_valid(3'b000);
        #5;
        for (int d = 0; d < 2; d++) chk("same_addr_second", d, rd2[d], 32'h87654321);
        cycle(w0, w1);
        #5;
        for (int d = 0; d < 2; d++) chk("same_addr_final", d, rfrd2[d], 32'h87654321);

        // Random traffic obeying the hold-until-accepted rule, per instance.
        prevw[0] = -1;
        prevw[1] = -1;
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 3; i++)
                    if (!valid[d][i] || prevw[d] == i) begin
                        valid[d][i] = 1'($urandom_range(0, 1));
                        addr[d][AW*i +: AW] = 3'($urandom);
                        data[d][DW*i +: DW] = $urandom;
                    end
            ra1 = 3'($urandom);
            ra2 = 3'($urandom);
            cycle(w0, w1);
            prevw[0] = w0;
            prevw[1] = w1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
